// File: rtl/of_ex_stall_ctrl_pkg.sv
// Shared definitions for the OF/EX pipeline control slice.
// Holds the opcode field encodings, the NOP instruction word and the
// run-length state type used by the stall controller.
package of_ex_stall_ctrl_pkg;

  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam logic [4:0] OP_ST   = 5'b01111;

  // NOP: opcode in [31:27], every other bit zero -> 32'h6800_0000
  localparam logic [31:0] NOP_INSN = {OP_NOP, 27'b0};

  typedef enum logic {
    RL_RUN   = 1'b0,
    RL_STALL = 1'b1
  } rl_state_t;

endpackage

// File: rtl/of_ex_stall_ctrl_pipe_reg.sv
// pipe_reg: parameterised pipeline latch.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high; loads bubble_val
//   load       - capture d
//   bubble     - load bubble_val (wins over load)
//   bubble_val - value used for reset and bubbles
//   d / q      - data in / latched data out
module pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] bubble_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q <= bubble_val;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/of_ex_stall_ctrl.sv
// of_ex_stall_ctrl: IF/OF and OF/EX pipeline latches with interlock stall,
// branch flush, saturating stall/flush counters and an overlong-stall flag.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RL_RUN   | pipeline advancing or flushing; run length is zero
// RL_STALL | inside a run of back-to-back interlock cycles
//
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   isDataInterLock                - RAW hazard on the instruction in OF
//   isBranchTaken                  - EX resolved a taken control transfer
//   IF_pc, IF_instruction          - fetch stage outputs
//   OF_A, OF_B, OF_op2             - operands read in OF
//   OF_pc, OF_instruction, OF_valid - IF/OF latch
//   EX_pc, EX_IR, EX_A, EX_B, EX_op2, EX_valid - OF/EX latch
//   pc_enable                      - combinational fetch advance enable
//   stall_count, flush_count       - saturating event counters
//   stall_error                    - sticky overlong-stall flag
module of_ex_stall_ctrl
  import of_ex_stall_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             isDataInterLock,
  input  logic             isBranchTaken,
  input  logic [31:0]      IF_pc,
  input  logic [31:0]      IF_instruction,
  input  logic [31:0]      OF_A,
  input  logic [31:0]      OF_B,
  input  logic [31:0]      OF_op2,
  output logic [31:0]      OF_pc,
  output logic [31:0]      OF_instruction,
  output logic             OF_valid,
  output logic [31:0]      EX_pc,
  output logic [31:0]      EX_IR,
  output logic [31:0]      EX_A,
  output logic [31:0]      EX_B,
  output logic [31:0]      EX_op2,
  output logic             EX_valid,
  output logic             pc_enable,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_error
);

  localparam int              RL_W   = $clog2(MAX_STALL + 2);
  localparam logic [RL_W-1:0] RL_SAT = RL_W'(MAX_STALL + 1);
  localparam logic [RL_W-1:0] RL_ONE = RL_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam int IFOF_W = 65;
  localparam int OFEX_W = 161;

  logic            stall;
  logic            advance;
  rl_state_t       rl_state;
  logic [RL_W-1:0] run_len;
  logic [RL_W-1:0] run_len_next;

  // A flush overrides the interlock; an empty OF slot cannot interlock.
  assign stall     = isDataInterLock & OF_valid & ~isBranchTaken;
  assign advance   = ~isBranchTaken & ~stall;
  assign pc_enable = ~reset & ~stall;

  pipe_reg #(.W(IFOF_W)) u_if_of (
    .clk        (clk),
    .reset      (reset),
    .load       (advance),
    .bubble     (isBranchTaken),
    .bubble_val ({1'b0, 32'h0, NOP_INSN}),
    .d          ({1'b1, IF_pc, IF_instruction}),
    .q          ({OF_valid, OF_pc, OF_instruction})
  );

  // A stalled OF instruction stays put, so EX receives a bubble instead.
  pipe_reg #(.W(OFEX_W)) u_of_ex (
    .clk        (clk),
    .reset      (reset),
    .load       (advance),
    .bubble     (isBranchTaken | stall),
    .bubble_val ({1'b0, 32'h0, NOP_INSN, 32'h0, 32'h0, 32'h0}),
    .d          ({OF_valid, OF_pc, OF_instruction, OF_A, OF_B, OF_op2}),
    .q          ({EX_valid, EX_pc, EX_IR, EX_A, EX_B, EX_op2})
  );

  // Length of the stall run including this cycle, saturating.
  always_comb begin
    run_len_next = RL_ONE;
    if (rl_state == RL_STALL) begin
      run_len_next = (run_len == RL_SAT) ? RL_SAT : run_len + RL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rl_state    <= RL_RUN;
      run_len     <= '0;
      stall_count <= '0;
      flush_count <= '0;
      stall_error <= 1'b0;
    end else if (isBranchTaken) begin
      rl_state <= RL_RUN;
      run_len  <= '0;
      if (flush_count != '1) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end else if (stall) begin
      rl_state <= RL_STALL;
      run_len  <= run_len_next;
      if (run_len_next == RL_SAT) begin
        stall_error <= 1'b1;
      end
      if (stall_count != '1) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end else begin
      rl_state <= RL_RUN;
      run_len  <= '0;
    end
  end

endmodule

// File: doc/of_ex_stall_ctrl.md
# of_ex_stall_ctrl

Pipeline control and latch block between fetch and execute. It holds the IF/OF and OF/EX pipeline registers and consumes the operand-fetch data-interlock flag and the EX branch outcome to stall, insert bubbles or flush. Its `OF_instruction` output drives the interlock checker. Its `EX_IR` output drives EX and the interlock checker's EX input.

## Interface
- `MAX_STALL`, default 3: maximum legal consecutive interlock cycles; longer sets `stall_error`.
- `CNT_W`, default 16: width of the saturating stall and flush counters.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `isDataInterLock` in 1: RAW hazard flag for the instruction currently in OF.
- `isBranchTaken` in 1: EX resolved a taken branch, call or ret this cycle.
- `IF_pc` in 32: fetched PC.
- `IF_instruction` in 32: fetched instruction.
- `OF_A` in 32: operand A read in OF.
- `OF_B` in 32: operand B read in OF.
- `OF_op2` in 32: second operand read in OF.
- `OF_pc` out 32: IF/OF latched PC.
- `OF_instruction` out 32: IF/OF latched instruction.
- `OF_valid` out 1: OF slot holds a real instruction.
- `EX_pc` out 32: OF/EX latch.
- `EX_IR` out 32: OF/EX latch.
- `EX_A` out 32: OF/EX latch.
- `EX_B` out 32: OF/EX latch.
- `EX_op2` out 32: OF/EX latch.
- `EX_valid` out 1: EX slot is not a bubble.
- `pc_enable` out 1: combinational; fetch may advance PC.
- `stall_count` out CNT_W: total interlock cycles, saturating.
- `flush_count` out CNT_W: total flush cycles, saturating.
- `stall_error` out 1: sticky; set when a stall exceeds `MAX_STALL` cycles.

## Operation
- NOP encoding: opcode 5'b01101 in [31:27], all other bits 0, giving 32'h6800_0000.
- Effective stall: `stall = isDataInterLock & OF_valid & ~isBranchTaken`.
- Per-cycle priority: reset > flush > stall > advance.
- Reset:
  - `OF_instruction`, `EX_IR` = NOP.
  - All PCs and operands = 0.
  - `OF_valid`, `EX_valid` = 0.
  - Both counters = 0, `stall_error` = 0, run-length counter = 0.
- Flush (`isBranchTaken`=1):
  - Both latches load NOP, with valid 0 and PC/operands 0.
  - `flush_count`++ (saturating).
  - Run-length counter cleared.
  - The interlock input is ignored this cycle.
- Stall:
  - IF/OF holds all fields.
  - OF/EX loads a bubble (NOP, valid 0, fields 0).
  - `stall_count`++ (saturating).
  - Run-length counter++.
- Advance:
  - IF/OF loads `IF_pc`/`IF_instruction` with valid 1.
  - OF/EX loads `OF_pc`, `OF_instruction`, `OF_A`, `OF_B`, `OF_op2`, and `EX_valid` <= `OF_valid`.
  - Run-length counter cleared.
- Run-length state: two states, RUN and STALL.
  - RUN→STALL on the first stall cycle.
  - STALL→RUN on advance or flush.
  - When run length reaches `MAX_STALL`+1, `stall_error` <= 1. It is cleared only by reset.
  - The run-length counter saturates at `MAX_STALL`+1.
- Counters stop at all-ones and never wrap.
- `pc_enable` = `~reset & ~stall`. It is 1 during a flush so fetch can load the target.

## Timing
- All latches have one-cycle latency: IF data at edge N appears on `OF_*` after edge N; an instruction that advances twice reaches `EX_*` two edges after fetch.
- `pc_enable` reacts in the same cycle, combinationally from `isDataInterLock`, `isBranchTaken`, `OF_valid` and `reset`.
- Stall cycles are back-to-back. An RW-distance hazard costs 1 cycle and an EX-distance hazard costs 3.
- Reset asserted mid-stall or mid-flush wins at that edge; all state returns to reset values.
- Interlock asserted while `OF_valid`=0 is ignored: no stall and no count.

## Structure
- Shared package holds the opcode constants (NOP 01101, b 10010, beq 10000, bgt 10001, call 10011, ret 10100, st 01111), `NOP_INSN` = 32'h6800_0000, and the run-length state enum.
- One sub-module, `pipe_reg`: a parameterised-width register with `load`, `bubble` and bubble-value inputs. It is instantiated once for IF/OF and once for OF/EX.
- Counters and the run-length FSM are kept in the top level.

## Test plan
- Reset: after reset, `OF_instruction` = `EX_IR` = 32'h6800_0000, both valids 0, counters 0, `stall_error` 0, `pc_enable` 0 during reset and 1 on the cycle after.
- Flow:
  - Stimulus: `IF_instruction` 32'h0048_C000 at PC 0x10, then 32'h0850_0000 at 0x14.
  - Required: 32'h0048_C000 appears on `OF_instruction` one edge later and on `EX_IR` two edges later, with `EX_valid` 1.
- 3-cycle interlock:
  - Stimulus: `isDataInterLock` high 3 cycles with `OF_valid`=1.
  - Required: `OF_instruction` held constant, `EX_IR` NOP for 3 cycles, `pc_enable` low 3 cycles, `stall_count` = 3, `stall_error` 0.
- Simultaneous events:
  - Stimulus: `isDataInterLock`=1 and `isBranchTaken`=1 in the same cycle.
  - Required: both latches become NOP with valid 0, `flush_count` = 1, `stall_count` unchanged, `pc_enable` 1.
- Overlong stall:
  - Stimulus: interlock held 4 cycles.
  - Required: `stall_error` rises after the 4th edge and stays 1 through later advances until reset.
- Saturation:
  - Stimulus: with `CNT_W`=4, 20 stall cycles interleaved with advances.
  - Required: `stall_count` = 15 and holds there; `flush_count` is unaffected.
